// File: rtl/network_acc_requant_pkg.sv
// Shared constants and types for the accumulate/requantize stage of the conv
// datapath.
//   DEF_*      default widths and shift used by network_acc_requant
//   ROUND_ADD  half-LSB added before the arithmetic right shift
//   OUT_MAX/OUT_MIN  signed output activation limits
//   state_t    accumulator control states (ACC, RQ)
package network_acc_requant_pkg;

    localparam int DEF_PROD_W = 30;
    localparam int DEF_ACC_W  = 40;
    localparam int DEF_BIAS_W = 16;
    localparam int DEF_OUT_W  = 16;
    localparam int DEF_SHIFT  = 14;

    localparam logic [DEF_ACC_W-1:0] ROUND_ADD = DEF_ACC_W'(1) << (DEF_SHIFT - 1);

    localparam logic signed [DEF_OUT_W-1:0] OUT_MAX = {1'b0, {(DEF_OUT_W-1){1'b1}}};
    localparam logic signed [DEF_OUT_W-1:0] OUT_MIN = {1'b1, {(DEF_OUT_W-1){1'b0}}};

    typedef enum logic {
        ACC,
        RQ
    } state_t;

endpackage

// File: rtl/network_requant_sat.sv
// Combinational requantizer: round half toward +inf, arithmetic shift right by
// SHIFT, saturate to a signed OUT_W result.
// Optional macro NETWORK_ACC_REQUANT_RELU_EN: negative results become 0 and
// o_sat flags positive overflow only.
// Ports:
//   i_acc   signed accumulator value
//   o_data  requantized signed result
//   o_sat   result was clamped
module network_requant_sat
    import network_acc_requant_pkg::*;
#(
    parameter int ACC_W = DEF_ACC_W,
    parameter int OUT_W = DEF_OUT_W,
    parameter int SHIFT = DEF_SHIFT
) (
    input  logic signed [ACC_W-1:0] i_acc,
    output logic signed [OUT_W-1:0] o_data,
    output logic                    o_sat
);

    // One extra bit so the rounding add cannot wrap near the accumulator limit.
    localparam int EXT_W = ACC_W + 1;
    localparam logic signed [EXT_W-1:0] L_ROUND = EXT_W'(1) << (SHIFT - 1);
    localparam logic signed [EXT_W-1:0] L_MAX   = (EXT_W'(1) << (OUT_W - 1)) - EXT_W'(1);
    localparam logic signed [EXT_W-1:0] L_MIN   = -(EXT_W'(1) << (OUT_W - 1));

    logic signed [EXT_W-1:0] w_sum;
    logic signed [EXT_W-1:0] w_r;
    logic                    w_pos_ovf;

    assign w_sum     = {i_acc[ACC_W-1], i_acc} + L_ROUND;
    assign w_r       = w_sum >>> SHIFT;
    assign w_pos_ovf = (w_r > L_MAX);

`ifdef NETWORK_ACC_REQUANT_RELU_EN
    always_comb begin
        o_data = w_r[OUT_W-1:0];
        o_sat  = 1'b0;
        if (w_r[EXT_W-1]) begin
            o_data = '0;
        end else if (w_pos_ovf) begin
            o_data = L_MAX[OUT_W-1:0];
            o_sat  = 1'b1;
        end
    end
`else
    logic w_neg_ovf;

    assign w_neg_ovf = (w_r < L_MIN);

    always_comb begin
        o_data = w_r[OUT_W-1:0];
        o_sat  = 1'b0;
        if (w_pos_ovf) begin
            o_data = L_MAX[OUT_W-1:0];
            o_sat  = 1'b1;
        end else if (w_neg_ovf) begin
            o_data = L_MIN[OUT_W-1:0];
            o_sat  = 1'b1;
        end
    end
`endif

endmodule

// File: rtl/network_acc_requant.sv
// Accumulates a group of signed products on top of a bias, then rounds,
// shifts and saturates the sum into a 16-bit activation on a valid/ready
// output. A new group may accumulate while the previous result waits.
// Optional macro NETWORK_ACC_REQUANT_RELU_EN enables ReLU on the output.
// Ports:
//   clk, reset            clock; asynchronous active-high reset
//   in_valid/in_ready     product beat handshake
//   in_data, in_last      signed product, last beat of group
//   bias                  signed bias, taken on the first beat only
//   out_valid/out_ready   result handshake
//   out_data, out_sat     requantized result, saturation flag
module network_acc_requant
    import network_acc_requant_pkg::*;
#(
    parameter int PROD_W = DEF_PROD_W,
    parameter int ACC_W  = DEF_ACC_W,
    parameter int BIAS_W = DEF_BIAS_W,
    parameter int OUT_W  = DEF_OUT_W,
    parameter int SHIFT  = DEF_SHIFT
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [PROD_W-1:0] in_data,
    input  logic                     in_last,
    input  logic signed [BIAS_W-1:0] bias,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [OUT_W-1:0]  out_data,
    output logic                     out_sat
);

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic                     r_first;
    logic signed [ACC_W-1:0]  r_acc;
    logic                     r_out_valid;
    logic signed [OUT_W-1:0]  r_out_data;
    logic                     r_out_sat;

    logic                     w_in_fire;
    logic                     w_load;
    logic signed [ACC_W-1:0]  w_prod_ext;
    logic signed [ACC_W-1:0]  w_bias_acc;
    logic signed [OUT_W-1:0]  w_q;
    logic                     w_q_sat;

    assign w_prod_ext = ACC_W'(in_data);
    assign w_bias_acc = ACC_W'(bias) <<< SHIFT;

    network_requant_sat #(
        .ACC_W (ACC_W),
        .OUT_W (OUT_W),
        .SHIFT (SHIFT)
    ) u_requant_sat (
        .i_acc  (r_acc),
        .o_data (w_q),
        .o_sat  (w_q_sat)
    );

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        w_in_fire   = 1'b0;
        w_load      = 1'b0;
        unique case (r_state)
            ACC: begin
                in_ready  = 1'b1;
                w_in_fire = in_valid;
                if (in_valid && in_last) begin
                    w_state_nxt = RQ;
                end
            end
            RQ: begin
                // Output register is free when empty or draining this cycle.
                w_load = !r_out_valid || out_ready;
                if (w_load) begin
                    w_state_nxt = ACC;
                end
            end
            default: w_state_nxt = ACC;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ACC;
            r_first <= 1'b1;
            r_acc   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_in_fire) begin
                r_first <= in_last;
                if (r_first) begin
                    r_acc <= w_bias_acc + w_prod_ext;
                end else begin
                    r_acc <= r_acc + w_prod_ext;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_sat   <= 1'b0;
        end else begin
            if (w_load) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_q;
                r_out_sat   <= w_q_sat;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_sat   = r_out_sat;

endmodule

// File: tb/tb_network_acc_requant.sv
// Directed testbench for network_acc_requant with hand-computed expectations.
module tb_network_acc_requant;

    logic               clk;
    logic               reset;
    logic               in_valid;
    logic               in_ready;
    logic signed [29:0] in_data;
    logic               in_last;
    logic signed [15:0] bias;
    logic               out_valid;
    logic               out_ready;
    logic signed [15:0] out_data;
    logic               out_sat;

    int n_tests;
    int n_fail;

    network_acc_requant #(
        .PROD_W (30),
        .ACC_W  (40),
        .BIAS_W (16),
        .OUT_W  (16),
        .SHIFT  (14)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .bias      (bias),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sat   (out_sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one beat and hold it until it is accepted (bounded).
    task automatic send_beat(input int d, input logic last, input int b);
        int k;
        k = 0;
        while (!in_ready && k < 50) begin
            tick();
            k++;
        end
        check("beat_ready", int'(in_ready), 1);
        in_valid = 1'b1;
        in_data  = 30'(d);
        in_last  = last;
        bias     = 16'(b);
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Wait (bounded) for a result with out_ready high, check and consume it.
    task automatic get_result(input string tag, input int exp_d, input int exp_s);
        int k;
        out_ready = 1'b1;
        k = 0;
        while (!out_valid && k < 50) begin
            tick();
            k++;
        end
        check({tag, "_valid"}, int'(out_valid), 1);
        check({tag, "_data"}, int'(out_data), exp_d);
        check({tag, "_sat"}, int'(out_sat), exp_s);
        tick();
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        bias      = '0;
        out_ready = 1'b1;
        #1;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_data", int'(out_data), 0);
        check("rst_out_sat", int'(out_sat), 0);
        tick();
        tick();
        reset = 1'b0;
        tick();
        check("rst_in_ready", int'(in_ready), 1);

        // 1: single beat, latency
        send_beat(16384, 1'b1, 0);
        check("t1_edge1_valid", int'(out_valid), 0);
        check("t1_edge1_in_ready", int'(in_ready), 0);
        tick();
        check("t1_edge2_valid", int'(out_valid), 1);
        check("t1_data", int'(out_data), 1);
        check("t1_sat", int'(out_sat), 0);
        tick();
        check("t1_drained", int'(out_valid), 0);

        // 2: rounding half toward +inf
        send_beat(8192, 1'b1, 0);
        get_result("t2_p8192", 1, 0);
        send_beat(-8192, 1'b1, 0);
        get_result("t2_m8192", 0, 0);
        send_beat(-8193, 1'b1, 0);
        get_result("t2_m8193", -1, 0);
        send_beat(8191, 1'b1, 0);
        get_result("t2_p8191", 0, 0);

        // 3: bias on first beat only, not carried into next group
        send_beat(16384, 1'b0, 3);
        send_beat(16384, 1'b0, 77);
        send_beat(-16384, 1'b1, 77);
        get_result("t3_bias", 4, 0);
        send_beat(16384, 1'b1, 0);
        get_result("t3_nobias", 1, 0);

        // 4: saturation
        send_beat(536870911, 1'b0, 0);
        send_beat(536870911, 1'b1, 0);
        get_result("t4_pos", 32767, 1);
        send_beat(-536870912, 1'b0, 0);
        send_beat(-536870912, 1'b1, 0);
`ifdef NETWORK_ACC_REQUANT_RELU_EN
        get_result("t4_neg", 0, 0);
`else
        get_result("t4_neg", -32768, 1);
`endif

        // 5: backpressure
        out_ready = 1'b0;
        send_beat(16384, 1'b1, 0);
        tick();
        check("t5_first_valid", int'(out_valid), 1);
        check("t5_first_data", int'(out_data), 1);
        send_beat(32768, 1'b1, 0);
        for (int i = 0; i < 3; i++) begin
            check("t5_stall_in_ready", int'(in_ready), 0);
            check("t5_hold_valid", int'(out_valid), 1);
            check("t5_hold_data", int'(out_data), 1);
            tick();
        end
        out_ready = 1'b1;
        tick();
        check("t5_b2b_valid", int'(out_valid), 1);
        check("t5_b2b_data", int'(out_data), 2);
        check("t5_b2b_in_ready", int'(in_ready), 1);
        tick();
        check("t5_drained", int'(out_valid), 0);

        // 6: reset mid-group
        out_ready = 1'b0;
        send_beat(536870911, 1'b0, 0);
        send_beat(536870911, 1'b1, 0);
        tick();
        check("t6_held_valid", int'(out_valid), 1);
        check("t6_held_sat", int'(out_sat), 1);
        send_beat(100, 1'b0, 5);
        send_beat(200, 1'b0, 5);
        reset = 1'b1;
        #1;
        check("t6_rst_valid", int'(out_valid), 0);
        check("t6_rst_data", int'(out_data), 0);
        check("t6_rst_sat", int'(out_sat), 0);
        check("t6_rst_in_ready", int'(in_ready), 1);
        tick();
        reset = 1'b0;
        tick();
        send_beat(16384, 1'b1, 0);
        get_result("t6_after", 1, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
